// File: rtl/pe_array_sequencer.sv
// Sequencer for one convolution pass on the PE chain: filter load, IFMap load, start, psum drain.
// Optional build macro PE_SEQ_STALL_CNT_EN adds the stall_cycles backpressure counter output.
module pe_array_sequencer #(
    parameter int unsigned N                        = 4,
    parameter int unsigned N_WIDTH                  = 2,
    parameter int unsigned GLOBAL_BUFFER_ADDR_WIDTH = 8,
    parameter int unsigned FILTER_SIZE_WIDTH        = 4,
    parameter int unsigned IFMAP_SIZE_WIDTH         = 5,
    parameter int unsigned FILTER_BASE              = 0,
    parameter int unsigned IFMAP_BASE               = 64,
    parameter int unsigned PSUM_BASE                = 192
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Start,
    input  logic [FILTER_SIZE_WIDTH-1:0]        filter_size,
    input  logic [IFMAP_SIZE_WIDTH-1:0]         ifmap_size,
    input  logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] num_psum,
    input  logic [N-1:0]                        ready_filter,
    input  logic [N-1:0]                        ready_ifmap,
    input  logic                                done_in,
    input  logic                                valid_psum,
    output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] raddr_global_buffer,
    output logic [GLOBAL_BUFFER_ADDR_WIDTH-1:0] waddr_global_buffer,
    output logic                                wen_global_buffer,
    output logic [N-1:0]                        wen_filter,
    output logic [N-1:0]                        wen_ifmap,
    output logic                                ren_psum,
    output logic                                Start_pe,
    output logic                                busy,
    output logic                                Done
`ifdef PE_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                         stall_cycles
`endif
);

    localparam int unsigned AW = GLOBAL_BUFFER_ADDR_WIDTH;
    localparam int unsigned KW = (FILTER_SIZE_WIDTH > IFMAP_SIZE_WIDTH) ?
                                 FILTER_SIZE_WIDTH : IFMAP_SIZE_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StLoadFlt,
        StLoadIfm,
        StStart,
        StRun,
        StFin
    } state_t;

    state_t                         r_state;
    logic   [N_WIDTH-1:0]           r_pe_idx;
    logic   [KW-1:0]                r_k;
    logic   [FILTER_SIZE_WIDTH-1:0] r_flt_size;
    logic   [IFMAP_SIZE_WIDTH-1:0]  r_ifm_size;
    logic   [AW-1:0]                r_num_psum;
    logic   [AW-1:0]                r_wr_cnt;
    logic                           r_done_seen;

    logic          w_in_flt;
    logic          w_in_ifm;
    logic          w_in_load;
    logic [KW-1:0] w_cur_size;
    logic          w_cur_ready;
    logic          w_load_wr;
    logic          w_last_word;
    logic          w_last_pe;
    logic [AW-1:0] w_offset;
    logic [N-1:0]  w_pe_onehot;
    logic          w_psum_wr;
    logic [AW-1:0] w_wr_cnt_nxt;
    logic          w_run_exit;
    logic          w_zero_size;

    assign w_in_flt    = (r_state == StLoadFlt);
    assign w_in_ifm    = (r_state == StLoadIfm);
    assign w_in_load   = w_in_flt | w_in_ifm;
    assign w_cur_size  = w_in_flt ? KW'(r_flt_size) : KW'(r_ifm_size);
    assign w_cur_ready = w_in_flt ? ready_filter[r_pe_idx] : ready_ifmap[r_pe_idx];
    assign w_load_wr   = w_in_load & w_cur_ready;
    assign w_last_word = (r_k == (w_cur_size - KW'(1)));
    assign w_last_pe   = (r_pe_idx == N_WIDTH'(N - 1));
    // Offset is formed at address width so wrap-around matches the buffer's modulo addressing.
    assign w_offset    = (AW'(r_pe_idx) * AW'(w_cur_size)) + AW'(r_k);
    assign w_pe_onehot = N'(1) << r_pe_idx;

    // Words beyond num_psum are left in the FIFO while waiting for done_in.
    assign w_psum_wr    = (r_state == StRun) & valid_psum & (r_wr_cnt != r_num_psum);
    assign w_wr_cnt_nxt = r_wr_cnt + AW'(w_psum_wr);
    assign w_run_exit   = (w_wr_cnt_nxt == r_num_psum) & (r_done_seen | done_in);

    assign w_zero_size = (filter_size == '0) | (ifmap_size == '0) | (num_psum == '0);

    always_comb begin
        raddr_global_buffer = '0;
        if (w_in_flt) begin
            raddr_global_buffer = AW'(FILTER_BASE) + w_offset;
        end else if (w_in_ifm) begin
            raddr_global_buffer = AW'(IFMAP_BASE) + w_offset;
        end
    end

    assign waddr_global_buffer = (r_state == StRun) ? (AW'(PSUM_BASE) + r_wr_cnt) : '0;
    assign wen_global_buffer   = w_psum_wr;
    assign ren_psum            = w_psum_wr;
    assign wen_filter          = (w_in_flt & w_cur_ready) ? w_pe_onehot : '0;
    assign wen_ifmap           = (w_in_ifm & w_cur_ready) ? w_pe_onehot : '0;
    assign Start_pe            = (r_state == StStart);
    assign Done                = (r_state == StFin);
    assign busy                = (r_state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_pe_idx    <= '0;
            r_k         <= '0;
            r_flt_size  <= '0;
            r_ifm_size  <= '0;
            r_num_psum  <= '0;
            r_wr_cnt    <= '0;
            r_done_seen <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        if (w_zero_size) begin
                            r_state <= StFin;
                        end else begin
                            r_flt_size  <= filter_size;
                            r_ifm_size  <= ifmap_size;
                            r_num_psum  <= num_psum;
                            r_pe_idx    <= '0;
                            r_k         <= '0;
                            r_wr_cnt    <= '0;
                            r_done_seen <= 1'b0;
                            r_state     <= StLoadFlt;
                        end
                    end
                end
                StLoadFlt, StLoadIfm: begin
                    if (w_load_wr) begin
                        if (w_last_word) begin
                            r_k <= '0;
                            if (w_last_pe) begin
                                r_pe_idx <= '0;
                                r_state  <= w_in_flt ? StLoadIfm : StStart;
                            end else begin
                                r_pe_idx <= r_pe_idx + N_WIDTH'(1);
                            end
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                StStart: r_state <= StRun;
                StRun: begin
                    r_wr_cnt <= w_wr_cnt_nxt;
                    if (done_in) begin
                        r_done_seen <= 1'b1;
                    end
                    if (w_run_exit) begin
                        r_state <= StFin;
                    end
                end
                StFin:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef PE_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (w_in_load & ~w_cur_ready) | ((r_state == StRun) & ~valid_psum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StIdle) && Start) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule
